// File: rtl/sdram_traffic_gen.sv
// SDRAM bus traffic generator and read-back checker.
// Writes a pattern over a window, reads it back and counts mismatches.
module sdram_traffic_gen #(
  parameter int          DW          = 16,
  parameter int          AW          = 24,
  parameter int          NUM_WORDS   = 1024,
  parameter int          BURST_BEATS = 4,
  parameter int          TIMEOUT     = 255,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode,
  input  logic [AW-1:0]   base_addr,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [15:0]     err_count,
  output logic [AW-1:0]   first_err_addr,
  output logic            bus_req_read,
  output logic            bus_req_write,
  output logic [AW-1:0]   bus_req_addr,
  output logic            bus_req_burst,
  output logic [2:0]      bus_req_burst_len,
  output logic [DW-1:0]   bus_req_wdata,
  output logic [DW/8-1:0] bus_req_byteenable,
  input  logic            bus_req_ready,
  input  logic            bus_rsp_valid,
  input  logic [DW-1:0]   bus_rsp_rdata
);

  localparam int CW = $clog2(NUM_WORDS) + 1;
  localparam int BW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam int RW = ((DW + 15) / 16) * 16;

  localparam logic [CW-1:0] NW      = CW'(NUM_WORDS);
  localparam logic [CW-1:0] NW_M1   = CW'(NUM_WORDS - 1);
  localparam logic [CW-1:0] NB      = CW'(BURST_BEATS);
  localparam logic [BW-1:0] B_LAST  = BW'(BURST_BEATS - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] A_MASK  = ~AW'(BURST_BEATS - 1);
  localparam logic [2:0]    BLEN    = 3'($clog2(BURST_BEATS));
  localparam logic          BURST   = (BURST_BEATS > 1);
  localparam logic [DW-1:0] XPAT    = {(DW/2){2'b01}};

  typedef enum logic [2:0] {
    IDLE, WR, RD_REQ, RD_WAIT, DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bcnt;
  logic [TW-1:0]   tcnt;
  logic [15:0]     lfsr;
  logic [AW-1:0]   base;
  logic            mode_q;

  logic [AW-1:0]   cur_addr;
  logic [AW-1:0]   beat_addr;
  logic [15:0]     lfsr_nx;
  logic [DW-1:0]   pat;
  logic            beat;
  logic            last_beat;
  logic            mism;
  logic            to_hit;
  logic [15:0]     err_nx;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] sh;
    sh = {1'b0, s[15:1]};
    return s[0] ? (sh ^ 16'hB400) : sh;
  endfunction

  function automatic logic [DW-1:0] pattern(
    input logic [AW-1:0] a,
    input logic [15:0]   s,
    input logic          m
  );
    logic [RW-1:0] rep;
    rep = {(RW/16){s}};
    if (m) return rep[DW-1:0];
    return DW'(a) ^ XPAT;
  endfunction

  // Datapath helpers: addresses, expected word, compare and timeout hit.
  always_comb begin
    cur_addr  = base + AW'(cnt);
    beat_addr = cur_addr + AW'(bcnt);
    lfsr_nx   = lfsr_step(lfsr);
    pat       = pattern(beat_addr, lfsr, mode_q);
    beat      = (state == RD_WAIT) && bus_rsp_valid;
    last_beat = beat && (bcnt == B_LAST);
    mism      = beat && (bus_rsp_rdata != pat);
    to_hit    = (state == RD_WAIT) && !last_beat && (tcnt == T_LAST);
    err_nx    = err_count;
    if (mism && (err_count != 16'hFFFF))
      err_nx = err_count + 16'd1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and bus request outputs.
  always_comb begin
    state_nx           = state;
    busy               = 1'b0;
    done               = 1'b0;
    bus_req_read       = 1'b0;
    bus_req_write      = 1'b0;
    bus_req_addr       = '0;
    bus_req_burst      = 1'b0;
    bus_req_burst_len  = 3'd0;
    bus_req_wdata      = '0;
    bus_req_byteenable = '1;
    unique case (state)
      IDLE: begin
        if (start) state_nx = WR;
      end
      WR: begin
        busy          = 1'b1;
        bus_req_write = 1'b1;
        bus_req_addr  = cur_addr;
        bus_req_wdata = pat;
        if (bus_req_ready && (cnt == NW_M1))
          state_nx = RD_REQ;
      end
      RD_REQ: begin
        busy              = 1'b1;
        bus_req_read      = 1'b1;
        bus_req_addr      = cur_addr;
        bus_req_burst     = BURST;
        bus_req_burst_len = BURST ? BLEN : 3'd0;
        if (bus_req_ready) state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        busy = 1'b1;
        if (last_beat)
          state_nx = ((cnt + NB) == NW) ? DONE : RD_REQ;
        else if (to_hit)
          state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nx = WR;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Counters, LFSR, error tracking and result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      bcnt           <= '0;
      tcnt           <= '0;
      lfsr           <= SEED;
      base           <= '0;
      mode_q         <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      timeout        <= 1'b0;
      pass           <= 1'b0;
    end else begin
      if (((state == IDLE) || (state == DONE)) && start) begin
        cnt            <= '0;
        bcnt           <= '0;
        tcnt           <= '0;
        lfsr           <= SEED;
        base           <= base_addr & A_MASK;
        mode_q         <= mode;
        err_count      <= '0;
        first_err_addr <= '0;
        timeout        <= 1'b0;
        pass           <= 1'b0;
      end
      if ((state == WR) && bus_req_ready) begin
        if (cnt == NW_M1) begin
          cnt  <= '0;
          lfsr <= SEED;
        end else begin
          cnt  <= cnt + 1'b1;
          lfsr <= lfsr_nx;
        end
      end
      if ((state == RD_REQ) && bus_req_ready) begin
        tcnt <= '0;
        bcnt <= '0;
      end
      if (state == RD_WAIT) begin
        tcnt <= tcnt + 1'b1;
        if (beat) begin
          lfsr      <= lfsr_nx;
          err_count <= err_nx;
          if (mism && (err_count == 16'd0))
            first_err_addr <= beat_addr;
          if (last_beat) begin
            bcnt <= '0;
            cnt  <= cnt + NB;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        if (to_hit) timeout <= 1'b1;
      end
      if ((state != DONE) && (state_nx == DONE))
        pass <= (err_nx == 16'd0) && !(timeout || to_hit);
    end
  end

endmodule

// File: tb/tb_sdram_traffic_gen.sv
// Bench for sdram_traffic_gen: scoreboarded slave model,
// error injection, backpressure, timeout, wrap and reset cases.
module tb_sdram_traffic_gen;

  localparam int DW = 16;
  localparam int AW = 24;
  localparam int NW = 16;
  localparam int BB = 4;
  localparam int TO = 40;
  localparam logic [15:0] SEED = 16'hACE1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            mode;
  logic [AW-1:0]   base_addr;
  logic            busy;
  logic            done;
  logic            pass;
  logic            timeout;
  logic [15:0]     err_count;
  logic [AW-1:0]   first_err_addr;
  logic            bus_req_read;
  logic            bus_req_write;
  logic [AW-1:0]   bus_req_addr;
  logic            bus_req_burst;
  logic [2:0]      bus_req_burst_len;
  logic [DW-1:0]   bus_req_wdata;
  logic [DW/8-1:0] bus_req_byteenable;
  logic            bus_req_ready;
  logic            bus_rsp_valid;
  logic [DW-1:0]   bus_rsp_rdata;

  sdram_traffic_gen #(
    .DW(DW), .AW(AW), .NUM_WORDS(NW),
    .BURST_BEATS(BB), .TIMEOUT(TO), .SEED(SEED)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .base_addr(base_addr), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .err_count(err_count),
    .first_err_addr(first_err_addr),
    .bus_req_read(bus_req_read),
    .bus_req_write(bus_req_write),
    .bus_req_addr(bus_req_addr),
    .bus_req_burst(bus_req_burst),
    .bus_req_burst_len(bus_req_burst_len),
    .bus_req_wdata(bus_req_wdata),
    .bus_req_byteenable(bus_req_byteenable),
    .bus_req_ready(bus_req_ready),
    .bus_rsp_valid(bus_rsp_valid),
    .bus_rsp_rdata(bus_rsp_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_nx(input logic [15:0] s);
    logic [15:0] sh;
    sh = s >> 1;
    return s[0] ? (sh ^ 16'hB400) : sh;
  endfunction

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_w[$];
  logic [AW-1:0] exp_r[$];
  logic [DW-1:0] wr_log[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  logic          bp = 1'b0;
  logic          corrupt = 1'b0;
  logic          no_rsp = 1'b0;
  logic [AW-1:0] bad_addr = '0;
  logic          rd_act = 1'b0;
  int            rd_wait = 0;
  int            rd_beat = 0;
  logic [AW-1:0] rd_base = '0;
  int            rd_acc_n = 0;
  int            first_rd_cyc = 0;

  // Slave model: checks requests against the scoreboard, returns data.
  initial begin
    logic                hold_v;
    logic [AW+DW+1:0]    held;
    wr_t                 e;
    logic [AW-1:0]       a;
    logic [DW-1:0]       d;
    hold_v        = 1'b0;
    held          = '0;
    bus_req_ready = 1'b1;
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v)
          check("req_hold",
                {bus_req_read, bus_req_write,
                 bus_req_addr, bus_req_wdata}, held);
        if (bus_req_write && bus_req_ready) begin
          mem[bus_req_addr] = bus_req_wdata;
          wr_log.push_back(bus_req_wdata);
          check("wr_be", bus_req_byteenable, 2'b11);
          if (exp_w.size() == 0) begin
            check("wr_extra", 1, 0);
          end else begin
            e = exp_w.pop_front();
            check("wr_addr", bus_req_addr, e.a);
            check("wr_data", bus_req_wdata, e.d);
          end
        end
        if (bus_req_read && bus_req_ready) begin
          rd_acc_n++;
          if (rd_acc_n == 1) first_rd_cyc = cyc + 1;
          if (exp_r.size() == 0)
            check("rd_extra", 1, 0);
          else
            check("rd_addr", bus_req_addr, exp_r.pop_front());
          check("rd_burst",
                {bus_req_burst, bus_req_burst_len}, 4'b1010);
          rd_act  = 1'b1;
          rd_wait = 1;
          rd_beat = 0;
          rd_base = bus_req_addr;
        end
        hold_v = (bus_req_read || bus_req_write) && !bus_req_ready;
        held   = {bus_req_read, bus_req_write,
                  bus_req_addr, bus_req_wdata};
      end
      @(posedge clk);
      #1;
      bus_req_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus_rsp_valid = 1'b0;
      if (rd_act && !no_rsp) begin
        if (rd_wait > 0) begin
          rd_wait--;
        end else begin
          a = rd_base + AW'(rd_beat);
          d = mem.exists(a) ? mem[a] : '0;
          if (corrupt && (a == bad_addr)) d[0] = ~d[0];
          bus_rsp_valid = 1'b1;
          bus_rsp_rdata = d;
          rd_beat++;
          if (rd_beat == BB) rd_act = 1'b0;
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic prep(input logic [AW-1:0] b, input logic m,
                      input logic bp_i, input logic cor_i,
                      input logic nors_i);
    logic [15:0]   s;
    logic [AW-1:0] a;
    bp       = bp_i;
    corrupt  = cor_i;
    no_rsp   = nors_i;
    rd_act   = 1'b0;
    rd_acc_n = 0;
    exp_w.delete();
    exp_r.delete();
    wr_log.delete();
    base_addr = b;
    mode      = m;
    s = SEED;
    for (int i = 0; i < NW; i++) begin
      a = b + AW'(i);
      exp_w.push_back({a, m ? s : (a[15:0] ^ 16'h5555)});
      s = lfsr_nx(s);
    end
    for (int k = 0; k < (nors_i ? 1 : NW / BB); k++)
      exp_r.push_back(b + AW'(k * BB));
  endtask

  task automatic run_test(input string name,
                          input logic [AW-1:0] b,
                          input logic m, input logic bp_i,
                          input logic cor_i, input logic nors_i,
                          input logic dbl,
                          input logic exp_pass,
                          input int exp_err,
                          input logic [AW-1:0] exp_first);
    int n;
    int c;
    prep(b, m, bp_i, cor_i, nors_i);
    pulse_start();
    check({name, "_busy"}, busy, 1'b1);
    if (dbl) begin
      @(negedge clk);
      pulse_start();
      check({name, "_busy_dbl"}, {busy, bus_req_write}, 2'b11);
    end
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    c = cyc;
    check({name, "_done"}, {done, busy}, 2'b10);
    check({name, "_pass"}, pass, exp_pass);
    check({name, "_err"}, err_count, exp_err);
    check({name, "_first"}, first_err_addr, exp_first);
    check({name, "_tmo"}, timeout, nors_i);
    check({name, "_wr_left"}, exp_w.size(), 0);
    check({name, "_rd_left"}, exp_r.size(), 0);
    if (nors_i)
      check({name, "_tmo_cyc"}, c - first_rd_cyc, TO);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctl"},
          {busy, done, pass, timeout, bus_req_read,
           bus_req_write, bus_req_burst, bus_req_burst_len,
           err_count}, '0);
    check({tag, "_dat"},
          {first_err_addr, bus_req_addr, bus_req_wdata}, '0);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    base_addr = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    run_test("ideal", 24'h000100, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, 1'b1, 0, 24'h0);

    bad_addr = 24'h000105;
    run_test("corrupt", 24'h000100, 1'b0, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b0, 1, 24'h000105);

    run_test("bp_lfsr", 24'h000200, 1'b1, 1'b1, 1'b0, 1'b0,
             1'b0, 1'b1, 0, 24'h0);
    check("lfsr_w0", (wr_log.size() > 0) ? wr_log[0] : 16'h0,
          16'hACE1);
    check("lfsr_w1", (wr_log.size() > 1) ? wr_log[1] : 16'h0,
          16'hE270);

    run_test("timeout", 24'h000100, 1'b0, 1'b0, 1'b0, 1'b1,
             1'b0, 1'b0, 0, 24'h0);

    run_test("wrap", 24'hFFFFF8, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, 1'b1, 0, 24'h0);

    prep(24'h000300, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_start();
    n = 0;
    while (rd_acc_n == 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("rst_rd_seen", rd_acc_n > 0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check_idle("rst_late");

    run_test("rerun", 24'h000300, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b1, 1'b1, 0, 24'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
